// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debounce front end.
// Holds the board clock rate and the board-level settle time in cycles (about 10 ms).
// Also provides the counter-width helper used to size each channel's stability counter.
package sw_debounce_pkg;

  // Board oscillator feeding core logic.
  localparam int unsigned BOARD_CLK_HZ = 100_000_000;

  // About 10 ms of settle time at the board clock; simulation overrides with small values.
  localparam int unsigned BOARD_STABLE_CYCLES = BOARD_CLK_HZ / 100;

  // Width needed to hold a count in the range 0..stable.
  function automatic int cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounce channel: a 2-flop synchronizer, a stability counter and the accepted level.
// Latency: db follows a held raw level STABLE_CYCLES+1 edges after the first sampling edge.
// No backpressure. upd is a combinational strobe that is high during the cycle whose closing edge loads db.
// Ports: clk, rst_n (async active-low), raw (async level), db (debounced level), upd (db loads this edge).
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = cnt_width(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic upd
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;

  logic w_diff;
  logic w_upd;

  // r_cnt counts the consecutive edges that have already seen r_s2 differ from r_db.
  // The level is accepted on the STABLE_CYCLES-th such edge.
  assign w_diff = r_s2 ^ r_db;
  assign w_upd  = w_diff && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
      if (!w_diff) begin
        // Any return to the accepted level discards the partial count.
        r_cnt <= '0;
      end else if (w_upd) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign db  = r_db;
  assign upd = w_upd;

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH slide switches plus the enable switch, each on an independent channel.
// Latency: a held level appears on the outputs STABLE_CYCLES+1 edges after it is first sampled.
// Outputs are plain levels with no handshake. changed pulses for one cycle after any level update.
// Ports: clk, rst_n (async active-low), raw_sw/raw_en (async inputs), sw/en (debounced), changed (pulse).
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = cnt_width(STABLE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_sw,
  input  logic             raw_en,
  output logic [WIDTH-1:0] sw,
  output logic             en,
  output logic             changed
);

  // The enable switch occupies the top channel so that it is handled exactly like the data switches.
  logic [WIDTH:0] w_raw;
  logic [WIDTH:0] w_db;
  logic [WIDTH:0] w_upd;
  logic           r_changed;

  assign w_raw = {raw_en, raw_sw};

  for (genvar i = 0; i <= WIDTH; i++) begin : g_ch
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (w_raw[i]),
      .db    (w_db[i]),
      .upd   (w_upd[i])
    );
  end

  // Registered alongside the db flops, so the pulse lines up with the new levels.
  // Several channels updating on the same edge produce a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_upd;
    end
  end

  assign sw      = w_db[WIDTH-1:0];
  assign en      = w_db[WIDTH];
  assign changed = r_changed;

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

  localparam int W = 8;
  localparam int S = 4;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b1;
  logic [W-1:0] raw_sw = '0;
  logic         raw_en = 1'b0;
  logic [W-1:0] sw;
  logic         en;
  logic         changed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH         (W),
    .STABLE_CYCLES (S)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_sw  (raw_sw),
    .raw_en  (raw_en),
    .sw      (sw),
    .en      (en),
    .changed (changed)
  );

  // Reference model: the raw vector sampled at each edge is kept in a history.
  // The synchronizer delays every sample by two edges.
  // A channel takes a new level at edge k when the S delayed samples ending at edge k-2 all differ from its current level.
  logic [W:0]   hist[$];
  logic [W:0]   m_db;
  logic [W+1:0] exp_q[$];

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + 1; i++) hist.push_back('0);
    m_db = '0;
  endtask

  always @(posedge clk) begin : model
    logic [W:0] nxt;
    logic [W:0] samp;
    bit         all_diff;
    samp = {raw_en, raw_sw};
    if (!rst_n) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      nxt = m_db;
      for (int c = 0; c <= W; c++) begin
        all_diff = 1'b1;
        for (int j = 0; j < S; j++)
          if (hist[hist.size() - 2 - j][c] == m_db[c]) all_diff = 1'b0;
        if (all_diff) nxt[c] = ~m_db[c];
      end
      exp_q.push_back({(nxt != m_db), nxt});
      m_db = nxt;
      hist.push_back(samp);
      if (hist.size() > S + 2) void'(hist.pop_front());
    end
  end

  // Monitor: the outputs are levels, so every cycle presents a value to compare.
  int pulses = 0;
  always @(negedge clk) begin : monitor
    logic [W+1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = '0;  // async reset already cleared the outputs
      checks++;
      if ({changed, en, sw} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got changed=%b en=%b sw=%h want changed=%b en=%b sw=%h",
                 $time, changed, en, sw, e[W+1], e[W], e[W-1:0]);
      end
      if (changed === 1'b1) pulses++;
    end
  end

  // Inputs change 2 time units after each rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_zero_now(input string name);
    checks++;
    if ({changed, en, sw} !== '0) begin
      errors++;
      $display("FAIL %s t=%0t got changed=%b en=%b sw=%h want all zero",
               name, $time, changed, en, sw);
    end
  endtask

  task automatic check_pulses(input string name, input int start, input int want);
    checks++;
    if (pulses - start != want) begin
      errors++;
      $display("FAIL %s got %0d changed pulses want %0d", name, pulses - start, want);
    end
  endtask

  initial begin
    int p0;
    #1 rst_n = 1'b0;
    // 1. Reset held while the switches read high.
    raw_sw = 8'hFF; raw_en = 1'b1;
    step(10);
    raw_sw = '0; raw_en = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(8);

    // 2. Clean change.
    p0 = pulses;
    raw_sw = 8'h24;
    step(10);
    check_pulses("clean_change_pulses", p0, 1);
    raw_sw = 8'h00;
    step(10);

    // 3. Glitch reject (3 cycles), then a 4-cycle pulse that must be accepted.
    p0 = pulses;
    raw_sw = 8'h08; step(3); raw_sw = 8'h00; step(10);
    check_pulses("glitch_reject_pulses", p0, 0);
    raw_sw = 8'h08; step(4); raw_sw = 8'h00; step(12);

    // 4. Bounce on the enable switch.
    p0 = pulses;
    raw_en = 1'b1; step(1); raw_en = 1'b0; step(1);
    raw_en = 1'b1; step(1); raw_en = 1'b0; step(1);
    raw_en = 1'b1; step(10);
    check_pulses("bounce_pulses", p0, 1);
    raw_en = 1'b0; step(10);

    // 5. Simultaneous change, then a separate change 2 cycles later.
    p0 = pulses;
    raw_sw[0] = 1'b1; raw_en = 1'b1; step(2);
    raw_sw[7] = 1'b1; step(10);
    check_pulses("simultaneous_pulses", p0, 2);

    // Async reset while outputs are nonzero: outputs must clear before the next edge.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check_zero_now("async_reset_clear");
    raw_sw = '0; raw_en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(8);

    // 6. Reset mid-count, then the full latency restarts with the raw level held.
    raw_sw = 8'h81; raw_en = 1'b1;
    step(3);
    #1 rst_n = 1'b0;
    #1 check_zero_now("midcount_reset_clear");
    step(1);
    rst_n = 1'b1;
    step(10);

    // Randomized phase with occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) raw_sw = raw_sw ^ W'($urandom);
      if ($urandom_range(0, 5) == 0) raw_en = ~raw_en;
      if ($urandom_range(0, 150) == 0) begin
        rst_n = 1'b0; step($urandom_range(1, 2)); rst_n = 1'b1;
      end
      step($urandom_range(1, 6));
    end
    step(12);

    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want at most 1", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
